mmu_feeder: RTL and testbench

Upstream sequencer for the `MMU3` systolic array. It replaces bench-driven stimulus with hardware control. On a start pulse it reads the weight matrix column by column from a wide weight memory and drives `wt_arr` with `control`=1 for `SIZE` cycles. It then streams `num_rows` activation vectors from an activation memory onto `data_arr` with `control`=0, optionally flushes the array with zero vectors, and pulses `done`.

---
 rtl/mmu_feeder_if.sv | 34 +++
 rtl/mmu_feeder.sv | 154 +++++++++++++++
 tb/tb_mmu_feeder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mmu_feeder_if.sv
// Bundle between mmu_feeder and its environment: control, weight/activation memory read ports,
// and the MMU3-facing array outputs. The master modport is the feeder's view.
interface mmu_feeder_if #(
    parameter int unsigned SIZE      = 4,
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned ADDR_W    = 16
);
    logic                      start;
    logic [ADDR_W-1:0]         num_rows;
    logic                      wt_rd_en;
    logic [ADDR_W-1:0]         wt_rd_addr;
    logic [SIZE*BIT_WIDTH-1:0] wt_rd_data;
    logic                      act_rd_en;
    logic [ADDR_W-1:0]         act_rd_addr;
    logic [SIZE*BIT_WIDTH-1:0] act_rd_data;
    logic                      control;
    logic [SIZE*BIT_WIDTH-1:0] wt_arr;
    logic [SIZE*BIT_WIDTH-1:0] data_arr;
    logic                      busy;
    logic                      done;
    logic [ADDR_W-1:0]         row_count;

    modport master (
        input  start, num_rows, wt_rd_data, act_rd_data,
        output wt_rd_en, wt_rd_addr, act_rd_en, act_rd_addr,
        output control, wt_arr, data_arr, busy, done, row_count
    );

    modport slave (
        output start, num_rows, wt_rd_data, act_rd_data,
        input  wt_rd_en, wt_rd_addr, act_rd_en, act_rd_addr,
        input  control, wt_arr, data_arr, busy, done, row_count
    );
endinterface

// File: rtl/mmu_feeder.sv
// Upstream sequencer for the MMU3 systolic array: loads weight columns (SIZE-1 down to 0),
// streams num_rows activation vectors, optionally flushes with zero vectors, then pulses done.
// Optional feature macro: MMU_FEEDER_FLUSH_EN adds 2*SIZE-1 zero vectors after the activations.
// Weights reach wt_arr through a register (2 cycles after the read); activations are gated onto
// data_arr in the cycle the memory returns them, so the first row directly follows the last
// weight column with no bubble.
module mmu_feeder #(
    parameter int unsigned SIZE      = 4,
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned ADDR_W    = 16
) (
    input logic          clk,
    input logic          rst_n,
    mmu_feeder_if.master bus
);
    typedef enum logic [2:0] {StIdle, StWload, StSwitch, StStream, StFlush, StDone} state_e;

`ifdef MMU_FEEDER_FLUSH_EN
    localparam state_e StAfterStream = StFlush;
    localparam int unsigned FlushW = $clog2(2 * SIZE);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(2 * SIZE - 2);
    logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
`else
    localparam state_e StAfterStream = StDone;
`endif

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         wt_addr_q, wt_addr_d;
    logic [ADDR_W-1:0]         act_addr_q, act_addr_d;
    logic [ADDR_W-1:0]         rows_q, rows_d;
    logic [ADDR_W-1:0]         row_count_q, row_count_d;
    logic                      wt_rd_en, act_rd_en;
    logic                      wt_vld_q, act_vld_q, control_q, done_q;
    logic [SIZE*BIT_WIDTH-1:0] wt_arr_q;

    // Next-state, address counters (saturating) and read strobes.
    always_comb begin
        state_d     = state_q;
        wt_addr_d   = wt_addr_q;
        act_addr_d  = act_addr_q;
        rows_d      = rows_q;
        row_count_d = row_count_q;
        wt_rd_en    = 1'b0;
        act_rd_en   = 1'b0;
`ifdef MMU_FEEDER_FLUSH_EN
        flush_cnt_d = flush_cnt_q;
`endif
        // A vector presented this cycle is counted at the following edge.
        if (act_vld_q) begin
            row_count_d = row_count_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    rows_d      = bus.num_rows;
                    row_count_d = '0;
                    wt_addr_d   = ADDR_W'(SIZE - 1);
                    act_addr_d  = '0;
`ifdef MMU_FEEDER_FLUSH_EN
                    flush_cnt_d = '0;
`endif
                    state_d     = StWload;
                end
            end
            StWload: begin
                wt_rd_en = 1'b1;
                if (wt_addr_q == '0) begin
                    state_d = StSwitch;
                end else begin
                    wt_addr_d = wt_addr_q - 1'b1;
                end
            end
            StSwitch: begin
                state_d = (rows_q != '0) ? StStream : StAfterStream;
            end
            StStream: begin
                act_rd_en = 1'b1;
                if (act_addr_q == rows_q - 1'b1) begin
                    state_d = StAfterStream;
                end else begin
                    act_addr_d = act_addr_q + 1'b1;
                end
            end
`ifdef MMU_FEEDER_FLUSH_EN
            StFlush: begin
                if (flush_cnt_q == FlushLast) begin
                    state_d = StDone;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wt_addr_q   <= '0;
            act_addr_q  <= '0;
            rows_q      <= '0;
            row_count_q <= '0;
`ifdef MMU_FEEDER_FLUSH_EN
            flush_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wt_addr_q   <= wt_addr_d;
            act_addr_q  <= act_addr_d;
            rows_q      <= rows_d;
            row_count_q <= row_count_d;
`ifdef MMU_FEEDER_FLUSH_EN
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end

    // Read-return tracking and the registered weight path toward MMU3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_vld_q  <= 1'b0;
            act_vld_q <= 1'b0;
            control_q <= 1'b0;
            done_q    <= 1'b0;
            wt_arr_q  <= '0;
        end else begin
            wt_vld_q  <= wt_rd_en;
            act_vld_q <= act_rd_en;
            control_q <= wt_vld_q;
            done_q    <= (state_q == StDone);
            if (wt_vld_q) begin
                wt_arr_q <= bus.wt_rd_data;
            end
        end
    end

    assign bus.wt_rd_en    = wt_rd_en;
    assign bus.wt_rd_addr  = wt_addr_q;
    assign bus.act_rd_en   = act_rd_en;
    assign bus.act_rd_addr = act_addr_q;
    assign bus.control     = control_q;
    assign bus.wt_arr      = wt_arr_q;
    assign bus.data_arr    = act_vld_q ? bus.act_rd_data : '0;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.row_count   = row_count_q;
endmodule

// File: tb/tb_mmu_feeder.sv
// Directed bench for mmu_feeder (SIZE=4): reset/idle, jobs with 3 and 0 rows, start during
// STREAM, and reset during WLOAD followed by a clean job.
module tb_mmu_feeder;
    localparam int unsigned SIZE = 4;
    localparam int unsigned BW   = 32;
    localparam int unsigned AW   = 16;
`ifdef MMU_FEEDER_FLUSH_EN
    localparam int FlushN = 7;
`else
    localparam int FlushN = 0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mmu_feeder_if #(.SIZE(SIZE), .BIT_WIDTH(BW), .ADDR_W(AW)) ifc ();

    mmu_feeder #(.SIZE(SIZE), .BIT_WIDTH(BW), .ADDR_W(AW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Column k = {k,k,k,k}.
    function automatic logic [127:0] col(input int k);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = 32'(k);
        return v;
    endfunction

    // Row r word i = 0x00A0_0000 | r<<8 | i.
    function automatic logic [127:0] row(input int r);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = 32'h00A0_0000 | 32'(r << 8) | 32'(i);
        return v;
    endfunction

    // Memories with 1-cycle read latency; junk when not read so ungated data shows up.
    always @(posedge clk) begin
        ifc.wt_rd_data  <= ifc.wt_rd_en  ? col(int'(ifc.wt_rd_addr))  : {4{32'hDEADBEEF}};
        ifc.act_rd_data <= ifc.act_rd_en ? row(int'(ifc.act_rd_addr)) : {4{32'hDEADBEEF}};
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wt_rd_en"},   128'(ifc.wt_rd_en),    128'd0);
        chk({tag, ".wt_rd_addr"}, 128'(ifc.wt_rd_addr),  128'd0);
        chk({tag, ".act_rd_en"},  128'(ifc.act_rd_en),   128'd0);
        chk({tag, ".act_rd_addr"},128'(ifc.act_rd_addr), 128'd0);
        chk({tag, ".control"},    128'(ifc.control),     128'd0);
        chk({tag, ".wt_arr"},     ifc.wt_arr,            128'd0);
        chk({tag, ".data_arr"},   ifc.data_arr,          128'd0);
        chk({tag, ".busy"},       128'(ifc.busy),        128'd0);
        chk({tag, ".done"},       128'(ifc.done),        128'd0);
        chk({tag, ".row_count"},  128'(ifc.row_count),   128'd0);
    endtask

    // Runs one job with r rows and checks every cycle E0+k; a second start is pulsed in
    // cycle E0+poke (poke < 0: never).
    task automatic run_job(input string tag, input int r, input int poke);
        int done_at;
        int dones;
        int rc;
        done_at = 6 + r + FlushN;
        dones   = 0;
        @(negedge clk);
        ifc.start    = 1'b1;
        ifc.num_rows = AW'(r);
        for (int k = 0; k <= done_at + 2; k++) begin
            @(negedge clk);
            if (k == 0) ifc.start = 1'b0;
            if (k == poke) begin
                ifc.start    = 1'b1;
                ifc.num_rows = 16'd9;
            end else if (k == poke + 1) begin
                ifc.start = 1'b0;
            end
            chk($sformatf("%s.wt_rd_en@%0d", tag, k), 128'(ifc.wt_rd_en), 128'(k <= 3));
            if (k <= 3)
                chk($sformatf("%s.wt_rd_addr@%0d", tag, k), 128'(ifc.wt_rd_addr), 128'(3 - k));
            chk($sformatf("%s.control@%0d", tag, k), 128'(ifc.control), 128'(k >= 2 && k <= 5));
            chk($sformatf("%s.wt_arr@%0d", tag, k), ifc.wt_arr,
                (k >= 2 && k <= 5) ? col(5 - k) : col(0));
            chk($sformatf("%s.act_rd_en@%0d", tag, k), 128'(ifc.act_rd_en),
                128'(k >= 5 && k < 5 + r));
            if (k >= 5 && k < 5 + r)
                chk($sformatf("%s.act_rd_addr@%0d", tag, k), 128'(ifc.act_rd_addr), 128'(k - 5));
            chk($sformatf("%s.data_arr@%0d", tag, k), ifc.data_arr,
                (k >= 6 && k < 6 + r) ? row(k - 6) : 128'd0);
            rc = (k < 6) ? 0 : ((k - 6 > r) ? r : k - 6);
            chk($sformatf("%s.row_count@%0d", tag, k), 128'(ifc.row_count), 128'(rc));
            chk($sformatf("%s.done@%0d", tag, k), 128'(ifc.done), 128'(k == done_at));
            chk($sformatf("%s.busy@%0d", tag, k), 128'(ifc.busy), 128'(k < done_at));
            if (ifc.done) dones++;
        end
        chk({tag, ".done_pulses"}, 128'(dones), 128'd1);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        ifc.start    = 1'b0;
        ifc.num_rows = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Idle: no reads, not busy.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("idle.wt_rd_en@%0d", k),  128'(ifc.wt_rd_en),  128'd0);
            chk($sformatf("idle.act_rd_en@%0d", k), 128'(ifc.act_rd_en), 128'd0);
            chk($sformatf("idle.busy@%0d", k),      128'(ifc.busy),      128'd0);
        end

        run_job("rows3", 3, -1);
        run_job("rows0", 0, -1);
        run_job("restart", 3, 6);

        // Reset during WLOAD aborts at once.
        @(negedge clk);
        ifc.start    = 1'b1;
        ifc.num_rows = 16'd3;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        chk("abort.busy_before", 128'(ifc.busy), 128'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort.done@%0d", k), 128'(ifc.done), 128'd0);
        end
        rst_n = 1'b1;
        run_job("after_abort", 3, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
